multicycle_ctrl_fsm: RTL

- Multi-cycle sequencer for the RV32I subset datapath (R-type, LW, SW, BEQ, ADDI-class I-type).
- Steps one instruction at a time through FETCH/DECODE/EXEC/MEM/WB.
- Drives the shared datapath strobes and the single unified memory port, using a req/ready handshake with timeout.
- Sits between the instruction register/opcode field and the datapath. Replaces single-cycle decode when instruction and data share one memory.

---
 rtl/multicycle_ctrl_fsm.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for an RV32I subset datapath sharing one memory port.
module multicycle_ctrl_fsm #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [6:0]       instr_opcode,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alusrc,
  output logic [1:0]       aluop,
  output logic             branch,
  output logic             reg_write,
  output logic             memtoreg,
  output logic             trap,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state_o
);

  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  state_t            state, state_next;
  logic [6:0]        opcode_q;
  logic [WAIT_W-1:0] wait_cnt;

  logic       req_c, read_c, write_c, iord_c, ir_write_c, pc_write_c, pc_src_c;
  logic       alusrc_c, branch_c, reg_write_c, memtoreg_c, retire_c, timeout_c;
  logic [1:0] aluop_c;

  // Last allowed wait cycle: a missing mem_ready here sends the sequencer to TRAP.
  assign timeout_c = (TIMEOUT != 0) && (wait_cnt == WAIT_W'(TIMEOUT - 1));

  // State, latched opcode, wait counter and retirement counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      opcode_q <= 7'd0;
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      state <= state_next;
      if (ir_write_c) opcode_q <= instr_opcode;
      if (state_next != state)         wait_cnt <= '0;
      else if (req_c && !mem_ready)    wait_cnt <= wait_cnt + WAIT_W'(1);
      if (retire_c) retired <= retired + CNT_W'(1);
    end
  end

  // Next-state and strobe decode from state, latched opcode and handshake inputs.
  always_comb begin
    state_next  = state;
    req_c       = 1'b0;
    read_c      = 1'b0;
    write_c     = 1'b0;
    iord_c      = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    pc_src_c    = 1'b0;
    alusrc_c    = 1'b0;
    aluop_c     = 2'b00;
    branch_c    = 1'b0;
    reg_write_c = 1'b0;
    memtoreg_c  = 1'b0;
    retire_c    = 1'b0;
    case (state)
      FETCH: begin
        if (run) begin
          req_c  = 1'b1;
          read_c = 1'b1;
          if (mem_ready) begin
            ir_write_c = 1'b1;
            pc_write_c = 1'b1;
            state_next = DECODE;
          end else if (timeout_c) begin
            state_next = TRAP;
          end
        end
      end
      DECODE: begin
        case (opcode_q)
          OP_R, OP_LW, OP_SW, OP_BEQ, OP_IMM: state_next = EXEC;
          default:                            state_next = TRAP;
        endcase
      end
      EXEC: begin
        case (opcode_q)
          OP_R: begin
            aluop_c    = 2'b10;
            state_next = WB;
          end
          OP_IMM: begin
            alusrc_c   = 1'b1;
            state_next = WB;
          end
          OP_LW, OP_SW: begin
            alusrc_c   = 1'b1;
            state_next = MEM;
          end
          OP_BEQ: begin
            aluop_c    = 2'b01;
            branch_c   = 1'b1;
            pc_write_c = alu_zero;
            pc_src_c   = alu_zero;
            retire_c   = 1'b1;
            state_next = FETCH;
          end
          default: state_next = TRAP;
        endcase
      end
      MEM: begin
        req_c   = 1'b1;
        iord_c  = 1'b1;
        read_c  = (opcode_q == OP_LW);
        write_c = (opcode_q == OP_SW);
        if (mem_ready) begin
          if (opcode_q == OP_SW) begin
            retire_c   = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = WB;
          end
        end else if (timeout_c) begin
          state_next = TRAP;
        end
      end
      WB: begin
        reg_write_c = 1'b1;
        memtoreg_c  = (opcode_q == OP_LW);
        retire_c    = 1'b1;
        state_next  = FETCH;
      end
      TRAP:    state_next = TRAP;
      default: state_next = TRAP;
    endcase
  end

  // Strobes are forced low for the whole time reset is held.
  assign mem_req   = req_c       & ~reset;
  assign mem_read  = read_c      & ~reset;
  assign mem_write = write_c     & ~reset;
  assign iord      = iord_c      & ~reset;
  assign ir_write  = ir_write_c  & ~reset;
  assign pc_write  = pc_write_c  & ~reset;
  assign pc_src    = pc_src_c    & ~reset;
  assign alusrc    = alusrc_c    & ~reset;
  assign aluop     = reset ? 2'b00 : aluop_c;
  assign branch    = branch_c    & ~reset;
  assign reg_write = reg_write_c & ~reset;
  assign memtoreg  = memtoreg_c  & ~reset;
  assign trap      = (state == TRAP) & ~reset;
  assign state_o   = state;

endmodule
